div_controller: RTL and testbench

Control FSM for the sequential restoring divider. Accepts a start request and sequences operand load, quotient-register initialisation, and WIDTH shift/subtract iterations. Drives the quotient-register controls (`q_init`, `loading_done`, `shift`) and the remainder-register controls, consuming the datapath's compare result `ge` and divisor-zero flag. Reports busy, done and divide-by-zero status to the host.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_controller_if.sv | 28 ++
 rtl/div_controller_iter_counter.sv | 36 +++
 rtl/div_controller.sv | 115 +++++++++++
 tb/tb_div_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider control path.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 10;

  // Counter must reach WIDTH-1 and also represent WIDTH itself.
  function automatic int unsigned cntw_for(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DIV_CNTW = cntw_for(DIV_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StInit,
    StIter,
    StFin,
    StErr
  } state_e;

endpackage

// File: rtl/div_controller_if.sv
// Host/datapath handshake bundle for the divider controller.
interface div_controller_if #(
  parameter int unsigned CNTW = 4
);
  logic            start;
  logic            dvsr_zero;
  logic            ge;
  logic            ld_operands;
  logic            q_init;
  logic            loading_done;
  logic            shift;
  logic            a_sub;
  logic            ldgt;
  logic            busy;
  logic            done;
  logic            dvz;
  logic [CNTW-1:0] count;

  modport master (
    output start, dvsr_zero, ge,
    input  ld_operands, q_init, loading_done, shift, a_sub, ldgt, busy, done, dvz, count
  );

  modport slave (
    input  start, dvsr_zero, ge,
    output ld_operands, q_init, loading_done, shift, a_sub, ldgt, busy, done, dvz, count
  );
endinterface

// File: rtl/div_controller_iter_counter.sv
// Iteration counter: synchronous clear (priority), enable, terminal flag at WIDTH-1.
module iter_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNTW  = 4
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [CNTW-1:0] count,
  output logic            tc
);

  logic [CNTW-1:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNTW'(1);
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CNTW'(WIDTH - 1));

endmodule

// File: rtl/div_controller.sv
// Control FSM for the restoring divider: load, init, WIDTH shift/subtract steps, done/dvz.
module div_controller
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNTW  = DIV_CNTW
) (
  input  logic         clock,
  input  logic         rst,
  div_controller_if.slave bus
);

  state_e state_q, state_d;
  logic   dvz_q, dvz_d;
  logic   cnt_clr, cnt_en, tc;

  logic ld_operands, q_init, loading_done, shift, busy, done;

  iter_counter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_iter_counter (
    .clock (clock),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (bus.count),
    .tc    (tc)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= StIdle;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvz_q   <= dvz_d;
    end
  end

  // dvz is set on entry to StErr so it is visible together with done.
  always_comb begin
    state_d = state_q;
    dvz_d   = dvz_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          dvz_d   = 1'b0;
        end
      end
      StLoad: state_d = StInit;
      StInit: begin
        if (bus.dvsr_zero) begin
          state_d = StErr;
          dvz_d   = 1'b1;
        end else begin
          cnt_clr = 1'b1;
          state_d = StIter;
        end
      end
      StIter: begin
        cnt_en = ~tc;
        if (tc) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ld_operands  = 1'b0;
    q_init       = 1'b0;
    loading_done = 1'b0;
    shift        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        ld_operands = 1'b1;
        busy        = 1'b1;
      end
      StInit: begin
        busy         = 1'b1;
        q_init       = ~bus.dvsr_zero;
        loading_done = ~bus.dvsr_zero;
      end
      StIter: begin
        busy         = 1'b1;
        loading_done = 1'b1;
        shift        = 1'b1;
      end
      StFin:   done = 1'b1;
      StErr:   done = 1'b1;
      default: ;
    endcase
  end

  assign bus.ld_operands  = ld_operands;
  assign bus.q_init       = q_init;
  assign bus.loading_done = loading_done;
  assign bus.shift        = shift;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.a_sub        = shift & bus.ge;
  assign bus.ldgt         = shift & bus.ge;
  assign bus.dvz          = dvz_q;

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: vector table, corner sequences, random vs model.
module tb_div_controller;
  import div_pkg::*;

  localparam int unsigned W  = DIV_WIDTH;
  localparam int unsigned CW = DIV_CNTW;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  div_controller_if #(.CNTW(CW)) bus ();

  div_controller #(
    .WIDTH (W),
    .CNTW  (CW)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int shift_cnt = 0;
  int last_done = -1;
  int done_log[$];

  // Model: m_k is the cycle index since start was accepted (0 = idle).
  int m_k = 0;
  bit m_err = 0;
  int m_count = 0;
  bit m_dvz = 0;

  logic s_ld, s_qi, s_sh, s_busy, s_done, s_dvz;
  logic [CW-1:0] s_count;

  typedef struct {
    logic r, s, d, g;
    logic ld, qi, sh, busy, done, dvz;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic g);
    logic e_ld, e_qi, e_ldn, e_sh, e_as, e_busy, e_done;
    rst = r; bus.start = s; bus.dvsr_zero = d; bus.ge = g;
    #4;
    e_ld = 0; e_qi = 0; e_ldn = 0; e_sh = 0; e_as = 0; e_busy = 0; e_done = 0;
    if (m_k == 1) begin
      e_ld = 1; e_busy = 1;
    end else if (m_k == 2) begin
      e_busy = 1; e_qi = !d; e_ldn = !d;
    end else if (m_err && m_k == 3) begin
      e_done = 1;
    end else if (!m_err && m_k >= 3 && m_k <= int'(W) + 2) begin
      e_busy = 1; e_ldn = 1; e_sh = 1; e_as = g;
    end else if (!m_err && m_k == int'(W) + 3) begin
      e_done = 1;
    end
    chk("ld_operands", 32'(bus.ld_operands), 32'(e_ld));
    chk("q_init", 32'(bus.q_init), 32'(e_qi));
    chk("loading_done", 32'(bus.loading_done), 32'(e_ldn));
    chk("shift", 32'(bus.shift), 32'(e_sh));
    chk("a_sub", 32'(bus.a_sub), 32'(e_as));
    chk("ldgt", 32'(bus.ldgt), 32'(e_as));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("dvz", 32'(bus.dvz), 32'(m_dvz));
    chk("count", 32'(bus.count), 32'(m_count));
    chk("qinit_shift_excl", 32'(bus.q_init & bus.shift), 32'd0);
    s_ld = bus.ld_operands; s_qi = bus.q_init; s_sh = bus.shift; s_busy = bus.busy;
    s_done = bus.done; s_dvz = bus.dvz; s_count = bus.count;
    if (bus.done === 1'b1) begin
      done_cnt++; last_done = cyc; done_log.push_back(cyc);
    end
    if (bus.shift === 1'b1) shift_cnt++;
    @(posedge clock);
    if (r) begin
      m_k = 0; m_err = 0; m_count = 0; m_dvz = 0;
    end else if (m_k == 0) begin
      if (s) begin m_k = 1; m_dvz = 0; end
    end else if (m_k == 1) begin
      m_k = 2;
    end else if (m_k == 2) begin
      m_k = 3;
      if (d) begin m_err = 1; m_dvz = 1; end
      else m_count = 0;
    end else if (m_err) begin
      m_k = 0; m_err = 0;
    end else if (m_k <= int'(W) + 2) begin
      if (m_k < int'(W) + 2) m_count = m_k - 2;
      m_k++;
    end else begin
      m_k = 0;
    end
    #1;
    cyc++;
  endtask

  initial begin
    int t0, d0, sh0;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.dvsr_zero = 1'b0; bus.ge = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, divide-by-zero with sticky dvz, clear on next start, reset mid-ITER.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].g);
      chk($sformatf("tbl%0d_ld", i), 32'(s_ld), 32'(tbl[i].ld));
      chk($sformatf("tbl%0d_qinit", i), 32'(s_qi), 32'(tbl[i].qi));
      chk($sformatf("tbl%0d_shift", i), 32'(s_sh), 32'(tbl[i].sh));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(s_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_dvz", i), 32'(s_dvz), 32'(tbl[i].dvz));
    end

    // Normal operation, ge toggling.
    t0 = cyc; d0 = done_cnt; sh0 = shift_cnt;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 14; i++) step(1'b0, 1'b0, 1'b0, i[0] ? 1'b1 : 1'b0);
    chk("normal_done_count", 32'(done_cnt - d0), 32'd1);
    chk("normal_done_latency", 32'(last_done - t0), 32'(W + 3));
    chk("normal_shift_cycles", 32'(shift_cnt - sh0), 32'(W));

    // Divide-by-zero latency.
    t0 = cyc; d0 = done_cnt; sh0 = shift_cnt;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("dvz_done_latency", 32'(last_done - t0), 32'd3);
    chk("dvz_no_shift", 32'(shift_cnt - sh0), 32'd0);
    chk("dvz_sticky", 32'(s_dvz), 32'd1);

    // Start ignored mid-op and in FIN; held into IDLE starts a new op.
    t0 = cyc; d0 = done_cnt;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 14 + int'(W) + 4; i++)
      step(1'b0, (i == 4 || i == 8 || i == int'(W) + 3 || i == int'(W) + 4) ? 1'b1 : 1'b0,
           1'b0, 1'(i % 3 == 0));
    chk("ignore_done_count", 32'(done_cnt - d0), 32'd2);
    chk("ignore_second_done", 32'(last_done - t0), 32'(2 * W + 4 + 3));

    // Reset held two cycles while count==5; no done pulse afterwards.
    t0 = cyc; d0 = done_cnt;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_count", 32'(bus.count), 32'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_after_busy", 32'(s_busy), 32'd0);
    chk("rst_after_count", 32'(s_count), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // Back-to-back with start held.
    t0 = cyc;
    done_log.delete();
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)));
    chk("b2b_done_count", 32'(done_log.size()), 32'd3);
    if (done_log.size() == 3) begin
      chk("b2b_done0", 32'(done_log[0] - t0), 32'(W + 3));
      chk("b2b_done1", 32'(done_log[1] - t0), 32'(2 * W + 7));
      chk("b2b_done2", 32'(done_log[2] - t0), 32'(3 * W + 11));
    end

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(63) == 0), 1'($urandom_range(3) == 0),
           1'($urandom_range(7) == 0), 1'($urandom_range(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
